mesh_inject_arbiter: RTL and testbench
======================================

// Module: mesh_inject_arbiter
// PURPOSE
// - Shares the local P-port injection channel of one mesh router among NUM_REQ on-tile traffic sources.
// - Grants the channel one whole packet at a time, in round-robin order.
// - Tracks router input-buffer space with a valid/yummy credit counter.
// - Sits between the tile sources and the router's dataIn_P/validIn_P/yummyOut_P pins.
// PARAMETERS
// - NUM_REQ     4    number of requesters (2..8)
// - DATA_WIDTH  64   flit width; equals the mesh `DATA_WIDTH
// - CREDITS     4    router P-port input buffer depth in flits (1..15)
// - LEN_LSB     22   LSB of the payload-length field in a header flit
// - LEN_W       8    width of the payload-length field (body flits after header)
// PORTS
// - clk         in   1                    clock
// - reset_in    in   1                    synchronous reset, active-low
// - req_valid   in   NUM_REQ              requester i has a flit on req_data[i]
// - req_data    in   NUM_REQ*DATA_WIDTH   flit of requester i at [i*DATA_WIDTH +: DATA_WIDTH]
// - req_ready   out  NUM_REQ              flit of requester i accepted this cycle
// - data_out    out  DATA_WIDTH           to router dataIn_P
// - valid_out   out  1                    to router validIn_P
// - yummy_in    in   1                    from router yummyOut_P; one credit returned
// - grant_id    out  $clog2(NUM_REQ)      current or last owner of the channel
// - busy        out  1                    a packet is in progress (state BODY)
// - credit_cnt  out  4                    free router buffer slots
// - err_credit  out  1                    sticky: yummy_in arrived while credit_cnt==CREDITS
// BEHAVIOUR
// - Reset (reset_in==0 at a clk edge), with priority over all other events:
//   - valid_out=0, data_out=0, credit_cnt=CREDITS, state=IDLE.
//   - rr_ptr=0, so requester 0 has highest priority; grant_id=0; busy=0; err_credit=0.
// - Accept condition: req_ready[i]=1 only when i is the selected requester, req_valid[i]=1 and credit_cnt>0.
//   - req_ready is combinational; at most one bit is set per cycle.
//   - An accepted flit appears on data_out with valid_out=1 exactly 1 cycle later (registered).
//   - valid_out=0 in any cycle following no acceptance; data_out holds its last value.
// - Credits, updated per cycle:
//   - Accept without yummy_in: -1. yummy_in without accept: +1. Both together: unchanged.
//   - Never below 0 (accept is blocked at 0).
//   - yummy_in at CREDITS saturates the counter and sets err_credit.
// - State IDLE (packet boundary):
//   - Selected requester = first i with req_valid[i]=1, searching from rr_ptr upward mod NUM_REQ.
//   - On accept, the flit is a header; len = flit[LEN_LSB +: LEN_W], grant_id <= i, rr_ptr <= (i+1) mod NUM_REQ.
//   - len==0: stay IDLE (single-flit packet). len>0: go to BODY with remain <= len.
//   - No valid requester, or credit_cnt==0: no accept, state held.
// - State BODY:
//   - Only grant_id may be accepted; all other req_ready stay 0 even if grant_id deasserts req_valid (bubbles allowed).
//   - Each accept does remain <= remain-1.
//   - Accept with remain==1: go to IDLE; arbitration resumes next cycle.
//   - busy=1 exactly while in BODY.
// - Header length LEN_W=8 gives max 255 body flits; remain is an LEN_W-bit down-counter and never wraps.
// - Mid-packet reset abandons the packet and restores credits. The router must be reset in the same cycle.
// - Flits are never dropped, reordered or interleaved across packets.
// TESTING
// - Reset: reset_in=0 for 2 cycles -> valid_out=0, credit_cnt=4, busy=0, err_credit=0, req_ready=0.
// - Single flit, credit loop:
//   - Req1 sends one header with len=0 -> req_ready[1] in cycle t, valid_out=1 with same data at t+1, credit_cnt=3.
//   - yummy_in pulse -> credit_cnt=4.
// - Atomicity and fairness:
//   - Req0 and req2 both valid, req0 header len=3 -> 4 consecutive req0 flits, no req2 flit in between.
//   - req2 is granted next, then req0 again (rr order 0,2,0).
// - Credit stall:
//   - Hold yummy_in=0 and send a 6-flit packet -> 4 flits accepted, req_ready=0 at credit_cnt=0.
//   - 2 yummy pulses -> remaining 2 flits accepted.
// - Simultaneous events:
//   - Accept and yummy_in in the same cycle -> credit_cnt unchanged.
//   - yummy_in at credit_cnt=4 -> credit_cnt stays 4, err_credit=1 until reset.
// - Mid-packet reset:
//   - Reset after 2 of 5 flits -> busy=0, credit_cnt=4, rr_ptr=0.
//   - Next grant goes to the lowest valid requester.

Source files
------------

// File: rtl/mesh_inject_arbiter.sv
// mesh_inject_arbiter: shares a mesh router's local P-port injection channel
// among NUM_REQ tile sources. Whole packets are granted in round-robin order,
// and router input-buffer space is tracked with a valid/yummy credit counter.
module mesh_inject_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int CREDITS    = 4,
    parameter int LEN_LSB    = 22,
    parameter int LEN_W      = 8,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset_in,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          valid_out,
    input  logic                          yummy_in,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic [3:0]                    credit_cnt,
    output logic                          err_credit
);

    localparam logic [3:0] CREDITS_V = 4'(CREDITS);

    typedef enum logic {
        IDLE,
        BODY
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       sel_idx;
    logic [ID_W-1:0]       cand_id;
    logic                  sel_found;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_flit;
    logic [LEN_W-1:0]      sel_len;
    logic [LEN_W-1:0]      remain;
    logic [3:0]            credit_next;

    assign busy = (state == BODY);

    // Pick the requester: owner during a packet, round-robin search from rr_ptr at a boundary
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_ptr;
        cand_id   = rr_ptr;
        if (state == BODY) begin
            sel_idx   = grant_id;
            sel_found = req_valid[grant_id];
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand_id = ID_W'((32'(rr_ptr) + k) % 32'(NUM_REQ));
                if (!sel_found && req_valid[cand_id]) begin
                    sel_found = 1'b1;
                    sel_idx   = cand_id;
                end
            end
        end
    end

    // Accept handshake, selected flit and its header length field
    always_comb begin
        accept    = sel_found && (credit_cnt != '0);
        req_ready = '0;
        if (accept) begin
            req_ready[sel_idx] = 1'b1;
        end
        sel_flit = req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
        sel_len  = sel_flit[LEN_LSB +: LEN_W];
    end

    // Credit counter next value; a credit return at full count saturates
    always_comb begin
        credit_next = credit_cnt;
        if (accept && !yummy_in) begin
            credit_next = credit_cnt - 4'd1;
        end else if (!accept && yummy_in && (credit_cnt != CREDITS_V)) begin
            credit_next = credit_cnt + 4'd1;
        end
    end

    // Packet FSM next-state: header with nonzero length opens a packet, last body flit closes it
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept && (sel_len != '0)) state_next = BODY;
            BODY: if (accept && (remain == LEN_W'(1))) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Output flit register, credits, ownership and body-flit down-counter
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            valid_out  <= 1'b0;
            data_out   <= '0;
            credit_cnt <= CREDITS_V;
            err_credit <= 1'b0;
            rr_ptr     <= '0;
            grant_id   <= '0;
            remain     <= '0;
        end else begin
            valid_out  <= accept;
            credit_cnt <= credit_next;
            if (accept) begin
                data_out <= sel_flit;
            end
            if (yummy_in && (credit_cnt == CREDITS_V)) begin
                err_credit <= 1'b1;
            end
            if (accept && (state == IDLE)) begin
                grant_id <= sel_idx;
                rr_ptr   <= (sel_idx == ID_W'(NUM_REQ - 1)) ? '0 : sel_idx + ID_W'(1);
                remain   <= sel_len;
            end else if (accept) begin
                remain <= remain - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mesh_inject_arbiter.sv
// Directed self-checking bench for mesh_inject_arbiter (default parameters).
module tb_mesh_inject_arbiter;

    logic         clk = 1'b0;
    logic         reset_in;
    logic [3:0]   req_valid;
    logic [255:0] req_data;
    logic [3:0]   req_ready;
    logic [63:0]  data_out;
    logic         valid_out;
    logic         yummy_in;
    logic [1:0]   grant_id;
    logic         busy;
    logic [3:0]   credit_cnt;
    logic         err_credit;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mesh_inject_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (64),
        .CREDITS    (4),
        .LEN_LSB    (22),
        .LEN_W      (8)
    ) dut (
        .clk        (clk),
        .reset_in   (reset_in),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .yummy_in   (yummy_in),
        .grant_id   (grant_id),
        .busy       (busy),
        .credit_cnt (credit_cnt),
        .err_credit (err_credit)
    );

    // Flit with a tag in the upper word and the length field at [29:22]
    function automatic logic [63:0] mkf(input logic [31:0] tag, input logic [7:0] len);
        return {tag, 2'b00, len, 22'd0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_in  = 1'b0;
        req_valid = '0;
        yummy_in  = 1'b0;
        tick();
        reset_in = 1'b1;
    endtask

    task automatic test_reset;
        reset_in  = 1'b0;
        req_valid = '0;
        req_data  = '0;
        yummy_in  = 1'b0;
        tick();
        tick();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0h want 0", valid_out); end
        total++; if (data_out !== 64'd0) begin bad++; $display("FAIL reset_data: got %0h want 0", data_out); end
        total++; if (credit_cnt !== 4'd4) begin bad++; $display("FAIL reset_credit: got %0d want 4", credit_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0h want 0", busy); end
        total++; if (err_credit !== 1'b0) begin bad++; $display("FAIL reset_err: got %0h want 0", err_credit); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        reset_in = 1'b1;
    endtask

    task automatic test_single_flit;
        logic [63:0] f;
        f = mkf(32'hA1, 8'd0);
        req_data[64 +: 64] = f;
        req_valid = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_ready: got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL single_valid: got %0h want 1", valid_out); end
        total++; if (data_out !== f) begin bad++; $display("FAIL single_data: got %0h want %0h", data_out, f); end
        total++; if (credit_cnt !== 4'd3) begin bad++; $display("FAIL single_credit: got %0d want 3", credit_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %0h want 0", busy); end
        total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL single_grant: got %0d want 1", grant_id); end
        yummy_in = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_idle_ready: got %b want 0000", req_ready); end
        tick();
        yummy_in = 1'b0;
        total++; if (credit_cnt !== 4'd4) begin bad++; $display("FAIL single_yummy_credit: got %0d want 4", credit_cnt); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL single_bubble_valid: got %0h want 0", valid_out); end
        total++; if (data_out !== f) begin bad++; $display("FAIL single_data_hold: got %0h want %0h", data_out, f); end
    endtask

    task automatic test_fairness;
        logic [63:0] d0 [7];
        logic [63:0] d2 [7];
        logic [63:0] ed [7];
        logic        y  [7];
        logic [3:0]  rdy[7];
        logic        ev [7];
        logic [3:0]  ec [7];
        logic        eb [7];
        logic [1:0]  eg [7];
        d0  = '{mkf(32'h10, 8'd3), mkf(32'h11, 8'd0), mkf(32'h12, 8'd0), mkf(32'h13, 8'd0),
                mkf(32'h14, 8'd0), mkf(32'h14, 8'd0), mkf(32'h14, 8'd0)};
        d2  = '{mkf(32'h20, 8'd0), mkf(32'h20, 8'd0), mkf(32'h20, 8'd0), mkf(32'h20, 8'd0),
                mkf(32'h20, 8'd0), mkf(32'h20, 8'd0), mkf(32'h21, 8'd0)};
        ed  = '{mkf(32'h10, 8'd3), mkf(32'h11, 8'd0), mkf(32'h12, 8'd0), mkf(32'h13, 8'd0),
                mkf(32'h13, 8'd0), mkf(32'h20, 8'd0), mkf(32'h14, 8'd0)};
        y   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        rdy = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0001};
        ev  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        ec  = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0};
        eb  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        eg  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            req_valid = 4'b0101;
            req_data[0 +: 64]   = d0[i];
            req_data[128 +: 64] = d2[i];
            yummy_in = y[i];
            #1;
            total++; if (req_ready !== rdy[i]) begin bad++; $display("FAIL fair_ready c%0d: got %b want %b", i, req_ready, rdy[i]); end
            tick();
            total++; if (valid_out !== ev[i]) begin bad++; $display("FAIL fair_valid c%0d: got %0h want %0h", i, valid_out, ev[i]); end
            total++; if (data_out !== ed[i]) begin bad++; $display("FAIL fair_data c%0d: got %0h want %0h", i, data_out, ed[i]); end
            total++; if (credit_cnt !== ec[i]) begin bad++; $display("FAIL fair_credit c%0d: got %0d want %0d", i, credit_cnt, ec[i]); end
            total++; if (busy !== eb[i]) begin bad++; $display("FAIL fair_busy c%0d: got %0h want %0h", i, busy, eb[i]); end
            total++; if (grant_id !== eg[i]) begin bad++; $display("FAIL fair_grant c%0d: got %0d want %0d", i, grant_id, eg[i]); end
        end
        req_valid = '0;
        yummy_in  = 1'b0;
    endtask

    task automatic test_credit_stall;
        logic [3:0]  rv [11];
        logic [63:0] d3 [11];
        logic [63:0] ed [11];
        logic        y  [11];
        logic [3:0]  rdy[11];
        logic        ev [11];
        logic [3:0]  ec [11];
        logic        eb [11];
        logic [1:0]  eg [11];
        rv  = '{4'b1000, 4'b1001, 4'b0001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0001, 4'b0001};
        d3  = '{mkf(32'h30, 8'd5), mkf(32'h31, 8'd0), mkf(32'h31, 8'd0), mkf(32'h32, 8'd0), mkf(32'h33, 8'd0),
                mkf(32'h34, 8'd0), mkf(32'h34, 8'd0), mkf(32'h34, 8'd0), mkf(32'h35, 8'd0), mkf(32'h35, 8'd0), mkf(32'h35, 8'd0)};
        ed  = '{mkf(32'h30, 8'd5), mkf(32'h31, 8'd0), mkf(32'h31, 8'd0), mkf(32'h32, 8'd0), mkf(32'h33, 8'd0),
                mkf(32'h33, 8'd0), mkf(32'h33, 8'd0), mkf(32'h34, 8'd0), mkf(32'h35, 8'd0), mkf(32'h35, 8'd0), mkf(32'h40, 8'd0)};
        y   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        rdy = '{4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        ev  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        ec  = '{4'd3, 4'd2, 4'd2, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd1, 4'd0};
        eb  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        eg  = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
        do_reset();
        req_data[0 +: 64] = mkf(32'h40, 8'd0);
        for (int i = 0; i < 11; i++) begin
            req_valid = rv[i];
            req_data[192 +: 64] = d3[i];
            yummy_in = y[i];
            #1;
            total++; if (req_ready !== rdy[i]) begin bad++; $display("FAIL stall_ready c%0d: got %b want %b", i, req_ready, rdy[i]); end
            tick();
            total++; if (valid_out !== ev[i]) begin bad++; $display("FAIL stall_valid c%0d: got %0h want %0h", i, valid_out, ev[i]); end
            total++; if (data_out !== ed[i]) begin bad++; $display("FAIL stall_data c%0d: got %0h want %0h", i, data_out, ed[i]); end
            total++; if (credit_cnt !== ec[i]) begin bad++; $display("FAIL stall_credit c%0d: got %0d want %0d", i, credit_cnt, ec[i]); end
            total++; if (busy !== eb[i]) begin bad++; $display("FAIL stall_busy c%0d: got %0h want %0h", i, busy, eb[i]); end
            total++; if (grant_id !== eg[i]) begin bad++; $display("FAIL stall_grant c%0d: got %0d want %0d", i, grant_id, eg[i]); end
        end
        req_valid = '0;
        yummy_in  = 1'b0;
    endtask

    task automatic test_credit_saturate;
        req_valid = '0;
        yummy_in  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (credit_cnt !== 4'(k + 1)) begin bad++; $display("FAIL sat_credit_up k%0d: got %0d want %0d", k, credit_cnt, k + 1); end
            total++; if (err_credit !== 1'b0) begin bad++; $display("FAIL sat_err_early k%0d: got %0h want 0", k, err_credit); end
        end
        tick();
        yummy_in = 1'b0;
        total++; if (credit_cnt !== 4'd4) begin bad++; $display("FAIL sat_credit_cap: got %0d want 4", credit_cnt); end
        total++; if (err_credit !== 1'b1) begin bad++; $display("FAIL sat_err_set: got %0h want 1", err_credit); end
        tick();
        tick();
        total++; if (err_credit !== 1'b1) begin bad++; $display("FAIL sat_err_sticky: got %0h want 1", err_credit); end
        total++; if (credit_cnt !== 4'd4) begin bad++; $display("FAIL sat_credit_hold: got %0d want 4", credit_cnt); end
    endtask

    task automatic test_mid_reset;
        logic [63:0] f;
        req_data[64 +: 64] = mkf(32'h50, 8'd4);
        req_valid = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mid_hdr_ready: got %b want 0010", req_ready); end
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %0h want 1", busy); end
        req_data[64 +: 64] = mkf(32'h51, 8'd0);
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mid_body_ready: got %b want 0010", req_ready); end
        tick();
        total++; if (credit_cnt !== 4'd2) begin bad++; $display("FAIL mid_credit: got %0d want 2", credit_cnt); end
        reset_in  = 1'b0;
        req_valid = 4'b1110;
        tick();
        reset_in = 1'b1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %0h want 0", busy); end
        total++; if (credit_cnt !== 4'd4) begin bad++; $display("FAIL mid_rst_credit: got %0d want 4", credit_cnt); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %0h want 0", valid_out); end
        total++; if (err_credit !== 1'b0) begin bad++; $display("FAIL mid_rst_err: got %0h want 0", err_credit); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL mid_rst_grant: got %0d want 0", grant_id); end
        f = mkf(32'h60, 8'd0);
        req_data[64 +: 64]  = f;
        req_data[128 +: 64] = mkf(32'h61, 8'd0);
        req_data[192 +: 64] = mkf(32'h62, 8'd0);
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mid_regrant_ready: got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        total++; if (data_out !== f) begin bad++; $display("FAIL mid_regrant_data: got %0h want %0h", data_out, f); end
        total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL mid_regrant_grant: got %0d want 1", grant_id); end
        total++; if (credit_cnt !== 4'd3) begin bad++; $display("FAIL mid_regrant_credit: got %0d want 3", credit_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_fairness();
        test_credit_stall();
        test_credit_saturate();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
